// File: rtl/fd_clock_divider_if.sv
// fd_clock_divider_if: control and output bundle of the programmable clock divider.
// master drives enable/ratio/load, slave (the divider) drives clk_out and tick.
interface fd_clock_divider_if #(
    parameter int unsigned DIV_WIDTH = 8
);
    logic                 en;
    logic [DIV_WIDTH-1:0] div_ratio;
    logic                 div_load;
    logic                 clk_out;
    logic                 tick;

    modport master (
        output en,
        output div_ratio,
        output div_load,
        input  clk_out,
        input  tick
    );

    modport slave (
        input  en,
        input  div_ratio,
        input  div_load,
        output clk_out,
        output tick
    );
endinterface

// File: rtl/fd_clock_divider.sv
// fd_clock_divider: programmable integer clock divider with rising-edge tick strobe.
// A new ratio is captured into a pending slot and adopted only when the counter
// wraps, so every output period is complete.
// Optional FD_ODD_DUTY50_EN adds a falling-edge stage that stretches the high
// phase of odd ratios by half a cycle for 50% duty.
module fd_clock_divider #(
    parameter int unsigned DIV_WIDTH   = 8,
    parameter int unsigned DEFAULT_DIV = 2
) (
    input  logic               clk,
    input  logic               rst,
    fd_clock_divider_if.slave  bus
);

    localparam int unsigned     W         = DIV_WIDTH;
    localparam logic [W-1:0]    RESET_DIV = W'(DEFAULT_DIV);
    localparam logic [W-1:0]    MIN_DIV   = W'(2);

    logic [W-1:0] cnt_q,  cnt_d;
    logic [W-1:0] n_q,    n_d;
    logic [W-1:0] p_q,    p_d;
    logic         pend_q, pend_d;
    logic         clk_q,  clk_d;
    logic         tick_q, tick_d;

    logic [W-1:0] half_c;
    logic         wrap_c;
    logic [W-1:0] ratio_c;

    // High-phase length, wrap detection and clamped load value.
    always_comb begin
        half_c  = n_q >> 1;
        wrap_c  = (cnt_q == (n_q - W'(1)));
        ratio_c = (bus.div_ratio < MIN_DIV) ? MIN_DIV : bus.div_ratio;
    end

    // Next-state: count, output level, tick, ratio adoption and capture.
    always_comb begin
        cnt_d  = cnt_q;
        n_d    = n_q;
        p_d    = p_q;
        pend_d = pend_q;
        clk_d  = clk_q;
        tick_d = 1'b0;

        if (bus.en) begin
            clk_d  = (cnt_q < half_c);
            tick_d = clk_d & ~clk_q;
            if (wrap_c) begin
                cnt_d = '0;
                if (pend_q) begin
                    n_d    = p_q;
                    pend_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + W'(1);
            end
        end

        // A load on a wrap edge lands in the pending slot for the next wrap.
        if (bus.div_load) begin
            p_d    = ratio_c;
            pend_d = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            n_q    <= RESET_DIV;
            p_q    <= RESET_DIV;
            pend_q <= 1'b0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            n_q    <= n_d;
            p_q    <= p_d;
            pend_q <= pend_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

    assign bus.tick = tick_q;

`ifdef FD_ODD_DUTY50_EN
    logic clk_fall_q;

    // Half-cycle delayed copy of the divided clock.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            clk_fall_q <= 1'b0;
        end else begin
            clk_fall_q <= clk_q;
        end
    end

    assign bus.clk_out = clk_q | (n_q[0] & clk_fall_q);
`else
    assign bus.clk_out = clk_q;
`endif

endmodule

// File: tb/tb_fd_clock_divider.sv
// tb_fd_clock_divider: scoreboard bench for fd_clock_divider.
// The reference model builds each output period as a whole waveform of N
// samples (floor(N/2) high, rest low) and replays it one enabled cycle at a time.
module tb_fd_clock_divider;

    localparam int unsigned DW = 8;

    typedef struct packed {
        logic clk_out;
        logic tick;
    } exp_t;

    logic clk;
    logic rst;

    fd_clock_divider_if #(.DIV_WIDTH(DW)) bus ();

    fd_clock_divider #(
        .DIV_WIDTH  (DW),
        .DEFAULT_DIV(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t sb_q[$];

    // Reference model state.
    int   m_n;
    int   m_p;
    bit   m_pend;
    bit   m_raw;
    bit   m_wave[$];

    function automatic void model_reset();
        m_n    = 2;
        m_p    = 2;
        m_pend = 1'b0;
        m_raw  = 1'b0;
        m_wave.delete();
    endfunction

    task automatic check_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, req);
        end
    endtask

    // Drive one cycle of inputs, advance the model on the edge, queue the expectation.
    task automatic step(input bit e, input bit ld, input int r);
        bit   prev;
        bit   tk;
        exp_t x;
        bus.en        = e;
        bus.div_load  = ld;
        bus.div_ratio = DW'(r);
        @(posedge clk);
        cyc++;
        prev = m_raw;
        tk   = 1'b0;
        if (e) begin
            if (m_wave.size() == 0) begin
                for (int i = 0; i < m_n; i++) m_wave.push_back(i < (m_n / 2));
                tk = 1'b1;
            end
            m_raw = m_wave.pop_front();
            if (m_wave.size() == 0 && m_pend) begin
                m_n    = m_p;
                m_pend = 1'b0;
            end
        end
        if (ld) begin
            m_p    = (r < 2) ? 2 : r;
            m_pend = 1'b1;
        end
`ifdef FD_ODD_DUTY50_EN
        x.clk_out = m_raw | (((m_n % 2) == 1) && prev);
`else
        x.clk_out = m_raw;
`endif
        x.tick = tk;
        sb_q.push_back(x);
        #1;
    endtask

    // Assert reset between edges, check the immediate effect, then release.
    task automatic mid_reset();
        #2;
        rst = 1'b0;
        #1;
        check_bit("async_rst_clk_out", bus.clk_out, 1'b0);
        check_bit("async_rst_tick", bus.tick, 1'b0);
        model_reset();
        #2;
        rst = 1'b1;
    endtask

    // Monitor: compare the DUT against the oldest queued expectation each cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if (bus.clk_out !== e.clk_out) begin
                    errors++;
                    $display("FAIL sb_clk_out cyc=%0d actual=%b required=%b", cyc, bus.clk_out, e.clk_out);
                end
                checks++;
                if (bus.tick !== e.tick) begin
                    errors++;
                    $display("FAIL sb_tick cyc=%0d actual=%b required=%b", cyc, bus.tick, e.tick);
                end
            end
        end
    end

    initial begin
        bit e;
        bit ld;
        int r;
        int guard;

        rst           = 1'b0;
        bus.en        = 1'b0;
        bus.div_load  = 1'b0;
        bus.div_ratio = '0;
        model_reset();

        // Reset state, then release at t=13 with en high.
        #2;
        check_bit("reset_clk_out", bus.clk_out, 1'b0);
        check_bit("reset_tick", bus.tick, 1'b0);
        #11;
        rst = 1'b1;
        for (int i = 0; i < 12; i++) step(1, 0, 0);

        // Asynchronous reset mid-run, then divide-by-2 restarts.
        mid_reset();
        for (int i = 0; i < 6; i++) step(1, 0, 0);

        // Ratio 5: load, then run across the adoption wrap.
        step(1, 1, 5);
        for (int i = 0; i < 30; i++) step(1, 0, 0);

        // Enable gating while clk_out is high.
        guard = 0;
        while (m_raw != 1'b1 && guard < 20) begin
            step(1, 0, 0);
            guard++;
        end
        check_bit("gate_setup_high", bus.clk_out, 1'b1);
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        for (int i = 0; i < 12; i++) step(1, 0, 0);

        // Clamp and overwrite: 1 then 4 before the wrap.
        step(1, 1, 1);
        step(1, 1, 4);
        for (int i = 0; i < 20; i++) step(1, 0, 0);

        // Loading 0 or 1 alone yields N=2.
        step(1, 1, 0);
        for (int i = 0; i < 12; i++) step(1, 0, 0);
        step(1, 1, 7);
        for (int i = 0; i < 16; i++) step(1, 0, 0);
        step(1, 1, 1);
        for (int i = 0; i < 16; i++) step(1, 0, 0);

        // Pending load discarded by reset.
        step(1, 1, 9);
        step(1, 0, 0);
        mid_reset();
        for (int i = 0; i < 8; i++) step(1, 0, 0);

        // Randomized enable, loads and ratios including the wide end.
        for (int i = 0; i < 600; i++) begin
            e  = ($urandom_range(0, 9) != 0);
            ld = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 15) == 0) r = int'($urandom_range(0, 40));
            else                            r = int'($urandom_range(0, 12));
            step(e, ld, r);
        end

        #10;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain actual=%0d required=0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
